// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer
//   Host-side initiator for the QEA load/run/readback protocol (QEA is the responder).
//   A job loads a stream of context words into QEA CTX RAM from address 0. It then
//   writes the |0..0> initial state into STATE RAM, pulses start and waits for complete.
//   Finally it reads every state row back and presents each row on a valid/ready
//   result stream.
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   i_cmd_start/i_qbit_num/i_ins_num job request, sampled only while idle
//   i_ctx_valid/i_ctx_data/o_ctx_ready context word stream in
//   o_ctx_en/o_ctx_wea/o_ctx_addr/o_ctx_data  QEA context RAM write port
//   o_qea_start/o_qbit_num           QEA start pulse and latched qubit count
//   o_state_ena/o_state_wea/o_state_addr/o_state_din  QEA state RAM port
//   i_qea_complete/i_state_dout      QEA completion flag and state read data
//   o_res_valid/i_res_ready/o_res_addr/o_res_data     result row stream out
//   o_busy/o_done/o_error            status (done/error are 1-cycle pulses)
module qea_host_sequencer #(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int RD_LATENCY              = 1,
    parameter int TIMEOUT_CYCLES          = 2**20
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_cmd_start,
    input  logic [MAX_QBIT_WIDTH-1:0]             i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]      i_ins_num,
    input  logic                                  i_ctx_valid,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]    i_ctx_data,
    output logic                                  o_ctx_ready,
    output logic                                  o_ctx_en,
    output logic                                  o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]    o_ctx_data,
    output logic                                  o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]             o_qbit_num,
    output logic                                  o_state_ena,
    output logic                                  o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]           o_state_addr,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]    o_state_din,
    input  logic                                  i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]    i_state_dout,
    output logic                                  o_res_valid,
    input  logic                                  i_res_ready,
    output logic [STATE_ADDR_WIDTH-1:0]           o_res_addr,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]    o_res_data,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_error
);

    localparam int SDW    = STATE_DATA_WIDTH;
    localparam int SAW    = STATE_ADDR_WIDTH;
    localparam int GCAW   = GATE_CONTEXT_ADDR_WIDTH;
    localparam int MQW    = MAX_QBIT_WIDTH;
    localparam int ROW_W  = PE_NUM * SDW;
    localparam int CCNT_W = GCAW + 1;   // must hold ins_num == 2**GCAW
    localparam int RCNT_W = SAW + 1;    // must hold ROWS == 2**SAW
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    // |0..0>: real part of the top lane amplitude is 1.0, everything else zero
    localparam logic [ROW_W-1:0] INIT_ROW =
        {{(SDW/2-NUM_FRAC_BIT-1){1'b0}}, 1'b1, {(ROW_W-SDW/2+NUM_FRAC_BIT){1'b0}}};

    typedef enum logic [3:0] {
        IDLE, LOAD_CTX, INIT_STATE, START, START_GAP,
        WAIT_CPL, RD_ISSUE, RD_WAIT, RD_HOLD, DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [MQW-1:0]           qbit_q;
    logic [CCNT_W-1:0]        ins_q;
    logic [CCNT_W-1:0]        ctx_cnt_q;
    logic [RCNT_W-1:0]        rows_q;
    logic [RCNT_W-1:0]        row_cnt_q;
    logic [WD_W-1:0]          wd_cnt_q;
    logic [LAT_W-1:0]         lat_cnt_q;
    logic                     ctx_en_q;
    logic [GCAW-1:0]          ctx_addr_q;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q;
    logic [ROW_W-1:0]         res_data_q;
    logic                     err_q;

    logic qbit_ok, ctx_fire, ctx_last, row_last, wd_last, lat_last;

    assign qbit_ok  = (i_qbit_num >= MQW'(2)) && (i_qbit_num <= MQW'(SAW + 2));
    assign ctx_fire = i_ctx_valid && (state_q == LOAD_CTX);
    assign ctx_last = (ctx_cnt_q + CCNT_W'(1)) == ins_q;
    assign row_last = row_cnt_q == (rows_q - RCNT_W'(1));
    assign wd_last  = wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1);
    assign lat_last = lat_cnt_q == LAT_W'(RD_LATENCY - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (i_cmd_start && qbit_ok)
                            state_d = (i_ins_num == '0) ? INIT_STATE : LOAD_CTX;
            LOAD_CTX:   if (ctx_fire && ctx_last) state_d = INIT_STATE;
            INIT_STATE: if (row_last) state_d = START;
            START:      state_d = START_GAP;
            START_GAP:  state_d = WAIT_CPL;
            WAIT_CPL:   if (i_qea_complete) state_d = RD_ISSUE;
                        else if (wd_last)   state_d = IDLE;
            RD_ISSUE:   state_d = RD_WAIT;
            RD_WAIT:    if (lat_last) state_d = RD_HOLD;
            RD_HOLD:    if (i_res_ready) state_d = row_last ? DONE : RD_ISSUE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            qbit_q     <= '0;
            ins_q      <= '0;
            ctx_cnt_q  <= '0;
            rows_q     <= '0;
            row_cnt_q  <= '0;
            wd_cnt_q   <= '0;
            lat_cnt_q  <= '0;
            ctx_en_q   <= 1'b0;
            ctx_addr_q <= '0;
            ctx_data_q <= '0;
            res_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= 1'b0;
            ctx_en_q <= 1'b0;
            case (state_q)
                IDLE: if (i_cmd_start) begin
                    if (qbit_ok) begin
                        qbit_q    <= i_qbit_num;
                        ins_q     <= i_ins_num;
                        rows_q    <= RCNT_W'(1) << (i_qbit_num - MQW'(2));
                        ctx_cnt_q <= '0;
                        row_cnt_q <= '0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                // context write is registered: the beat accepted now is written next cycle
                LOAD_CTX: if (ctx_fire) begin
                    ctx_en_q   <= 1'b1;
                    ctx_addr_q <= ctx_cnt_q[GCAW-1:0];
                    ctx_data_q <= i_ctx_data;
                    ctx_cnt_q  <= ctx_cnt_q + CCNT_W'(1);
                end
                INIT_STATE: row_cnt_q <= row_last ? '0 : row_cnt_q + RCNT_W'(1);
                START:      wd_cnt_q  <= '0;
                WAIT_CPL: begin
                    wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    if (i_qea_complete) row_cnt_q <= '0;
                    else if (wd_last)   err_q     <= 1'b1;
                end
                RD_ISSUE: lat_cnt_q <= '0;
                RD_WAIT: begin
                    lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                    if (lat_last) res_data_q <= i_state_dout;
                end
                RD_HOLD: if (i_res_ready && !row_last) row_cnt_q <= row_cnt_q + RCNT_W'(1);
                default: ;
            endcase
        end
    end

    assign o_ctx_ready  = (state_q == LOAD_CTX);
    assign o_ctx_en     = ctx_en_q;
    assign o_ctx_wea    = ctx_en_q;
    assign o_ctx_addr   = ctx_addr_q;
    assign o_ctx_data   = ctx_data_q;
    assign o_qea_start  = (state_q == START);
    assign o_qbit_num   = qbit_q;
    assign o_state_ena  = (state_q == INIT_STATE) || (state_q == RD_ISSUE);
    assign o_state_wea  = (state_q == INIT_STATE);
    assign o_state_addr = row_cnt_q[SAW-1:0];
    assign o_state_din  = ((state_q == INIT_STATE) && (row_cnt_q == '0)) ? INIT_ROW : '0;
    assign o_res_valid  = (state_q == RD_HOLD);
    assign o_res_addr   = row_cnt_q[SAW-1:0];
    assign o_res_data   = res_data_q;
    assign o_busy       = (state_q != IDLE);
    assign o_done       = (state_q == DONE);
    assign o_error      = err_q;

endmodule

// File: tb/tb_qea_host_sequencer.sv
`timescale 1ns/1ps
module tb_qea_host_sequencer;
    localparam int PE = 4, SDW = 64, SAW = 16, GCDW = 64, GCAW = 16, MQW = 6;
    localparam int TO = 300;
    localparam int RW = PE * SDW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_cmd_start = 1'b0;
    logic [MQW-1:0]    i_qbit_num = '0;
    logic [GCAW:0]     i_ins_num = '0;
    logic              i_ctx_valid = 1'b0;
    logic [GCDW-1:0]   i_ctx_data = '0;
    logic              o_ctx_ready, o_ctx_en, o_ctx_wea;
    logic [GCAW-1:0]   o_ctx_addr;
    logic [GCDW-1:0]   o_ctx_data;
    logic              o_qea_start;
    logic [MQW-1:0]    o_qbit_num;
    logic              o_state_ena, o_state_wea;
    logic [SAW-1:0]    o_state_addr;
    logic [RW-1:0]     o_state_din;
    logic              i_qea_complete = 1'b0;
    logic [RW-1:0]     i_state_dout = '0;
    logic              o_res_valid;
    logic              i_res_ready = 1'b0;
    logic [SAW-1:0]    o_res_addr;
    logic [RW-1:0]     o_res_data;
    logic              o_busy, o_done, o_error;

    qea_host_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .i_cmd_start(i_cmd_start), .i_qbit_num(i_qbit_num),
        .i_ins_num(i_ins_num), .i_ctx_valid(i_ctx_valid), .i_ctx_data(i_ctx_data),
        .o_ctx_ready(o_ctx_ready), .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
        .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data), .o_qea_start(o_qea_start),
        .o_qbit_num(o_qbit_num), .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
        .o_state_addr(o_state_addr), .o_state_din(o_state_din),
        .i_qea_complete(i_qea_complete), .i_state_dout(i_state_dout),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_addr(o_res_addr),
        .o_res_data(o_res_data), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    // QEA state RAM stand-in: a read returns the row index in every lane, one cycle later
    always @(posedge clk)
        if (o_state_ena && !o_state_wea) i_state_dout <= {PE{{48'h0, o_state_addr}}};

    // Event logs, sampled on the falling edge
    int              cyc = 0;
    logic [GCAW-1:0] cw_addr[$];
    logic [GCDW-1:0] cw_data[$];
    int              cw_cyc[$];
    logic [SAW-1:0]  sw_addr[$];
    logic [RW-1:0]   sw_data[$];
    logic [SAW-1:0]  sr_addr[$];
    logic [SAW-1:0]  rs_addr[$];
    logic [RW-1:0]   rs_data[$];
    int start_cnt = 0, start_cyc = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0;
    int act_cnt = 0, busy_cnt = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (o_ctx_en && o_ctx_wea) begin
                cw_addr.push_back(o_ctx_addr);
                cw_data.push_back(o_ctx_data);
                cw_cyc.push_back(cyc);
            end
            if (o_state_ena && o_state_wea) begin
                sw_addr.push_back(o_state_addr);
                sw_data.push_back(o_state_din);
            end
            if (o_state_ena && !o_state_wea) sr_addr.push_back(o_state_addr);
            if (o_res_valid && i_res_ready) begin
                rs_addr.push_back(o_res_addr);
                rs_data.push_back(o_res_data);
            end
            if (o_qea_start) begin start_cnt <= start_cnt + 1; start_cyc <= cyc; end
            if (o_error)     begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
            if (o_done)      done_cnt <= done_cnt + 1;
            if (o_busy)      busy_cnt <= busy_cnt + 1;
            if (o_ctx_en || o_state_ena || o_qea_start) act_cnt <= act_cnt + 1;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [GCDW-1:0] ctx_word(input int i);
        return {32'hC7C7_0000 + 32'(i), 32'h1234_0000 ^ 32'(i)};
    endfunction

    function automatic logic [RW-1:0] row_word(input int r);
        logic [RW-1:0] w;
        for (int l = 0; l < PE; l++) w[l*64 +: 64] = 64'(r);
        return w;
    endfunction

    function automatic logic [9:0] ctrl_vec();
        return {o_busy, o_ctx_ready, o_ctx_en, o_ctx_wea, o_qea_start,
                o_state_ena, o_state_wea, o_res_valid, o_done, o_error};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic cmd(input int qbit, input int ins);
        i_qbit_num  = MQW'(qbit);
        i_ins_num   = (GCAW+1)'(ins);
        i_cmd_start = 1'b1;
        tick(1);
        i_cmd_start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gap);
        int  beat = 0;
        int  g = 0;
        bit  ph = 1'b1;
        while (beat < n && g < 5000) begin
            i_ctx_valid = gap ? ph : 1'b1;
            i_ctx_data  = ctx_word(beat);
            ph = !ph;
            if (i_ctx_valid && o_ctx_ready) beat++;
            tick(1);
            g++;
        end
        i_ctx_valid = 1'b0;
        check("feed_beats", beat, n);
    endtask

    task automatic check_ctx(input int base, input int n, input bit gap);
        int bad = 0, gbad = 0;
        check("ctx_writes", cw_addr.size() - base, n);
        for (int k = 0; k < n && base + k < cw_addr.size(); k++) begin
            if (cw_addr[base+k] !== GCAW'(k) || cw_data[base+k] !== ctx_word(k)) bad++;
            if (gap && k > 0 && cw_cyc[base+k] - cw_cyc[base+k-1] != 2) gbad++;
        end
        check("ctx_order", bad, 0);
        if (gap) check("ctx_gaps", gbad, 0);
    endtask

    task automatic wait_start_complete(input int sbase);
        int g = 0;
        while (start_cnt == sbase && g < 2000) begin tick(1); g++; end
        check("start_seen", start_cnt - sbase, 1);
        tick(50);
        i_qea_complete = 1'b1;
        tick(1);
        i_qea_complete = 1'b0;
    endtask

    task automatic collect(input int rbase, input int dbase, input int rows, input bit hold0);
        int g = 0, bad = 0, rd0;
        logic [SAW-1:0] a0;
        logic [RW-1:0]  d0;
        if (hold0) begin
            i_res_ready = 1'b0;
            while (!o_res_valid && g < 500) begin tick(1); g++; end
            a0 = o_res_addr;
            d0 = o_res_data;
            rd0 = sr_addr.size();
            for (int c = 0; c < 10; c++) begin
                tick(1);
                if (!o_res_valid || o_res_addr !== a0 || o_res_data !== d0) bad++;
            end
            check("hold_stable", bad, 0);
            check("hold_row0_addr", a0, 0);
            check("hold_single_read", sr_addr.size() - rd0, 0);
        end
        i_res_ready = 1'b1;
        g = 0;
        while (done_cnt == dbase && g < 500) begin tick(1); g++; end
        tick(2);
        i_res_ready = 1'b0;
        check("done_pulses", done_cnt - dbase, 1);
        check("res_rows", rs_addr.size() - rbase, rows);
        for (int k = 0; k < rows && rbase + k < rs_addr.size(); k++) begin
            check($sformatf("res_addr%0d", k), rs_addr[rbase+k], k);
            check($sformatf("res_data%0d", k), rs_data[rbase+k], row_word(k));
        end
        check("idle_after_job", o_busy, 0);
    endtask

    localparam logic [RW-1:0] ROW0 = {64'h4000_0000_0000_0000, 192'h0};

    initial begin : main
        int cb, sb, rb, db, eb, ab, bb, wb, srb;
        // reset
        tick(3);
        check("rst_ctrl", ctrl_vec(), 0);
        check("rst_ctx", {o_ctx_addr, o_ctx_data, o_qbit_num}, 0);
        check("rst_res", {o_res_data, o_res_addr}, 0);
        rst = 1'b0;
        tick(2);
        check("idle_ctrl", ctrl_vec(), 0);

        // job A: continuous valid, ready held high
        cb = cw_addr.size(); wb = sw_addr.size(); sb = start_cnt;
        rb = rs_addr.size(); db = done_cnt; eb = err_cnt; srb = sr_addr.size();
        i_res_ready = 1'b1;
        cmd(3, 149);
        check("qbit_latched", o_qbit_num, 3);
        feed(149, 1'b0);
        tick(4);
        check_ctx(cb, 149, 1'b0);
        check("a_state_writes", sw_addr.size() - wb, 2);
        check("a_row0_addr", sw_addr[wb], 0);
        check("a_row0_data", sw_data[wb], ROW0);
        check("a_row1_addr", sw_addr[wb+1], 1);
        check("a_row1_data", sw_data[wb+1], 0);
        wait_start_complete(sb);
        collect(rb, db, 2, 1'b0);
        check("a_starts", start_cnt - sb, 1);
        check("a_reads", sr_addr.size() - srb, 2);
        check("a_no_error", err_cnt - eb, 0);

        // job B: valid every other cycle, result 0 held for 10 cycles
        cb = cw_addr.size(); wb = sw_addr.size(); sb = start_cnt;
        rb = rs_addr.size(); db = done_cnt;
        i_ctx_valid = 1'b1;       // ignored while idle
        tick(2);
        i_ctx_valid = 1'b0;
        check("b_idle_no_ctx", cw_addr.size() - cb, 0);
        cmd(3, 149);
        feed(149, 1'b1);
        tick(4);
        check_ctx(cb, 149, 1'b1);
        check("b_state_writes", sw_addr.size() - wb, 2);
        check("b_row0_data", sw_data[wb], ROW0);
        wait_start_complete(sb);
        collect(rb, db, 2, 1'b1);

        // bad qubit counts
        eb = err_cnt; ab = act_cnt; bb = busy_cnt;
        cmd(1, 4);
        tick(3);
        check("q1_error", err_cnt - eb, 1);
        cmd(SAW + 3, 4);
        tick(3);
        check("q19_error", err_cnt - eb, 2);
        check("badq_no_activity", act_cnt - ab, 0);
        check("badq_not_busy", busy_cnt - bb, 0);

        // smallest job: one row, no context words
        cb = cw_addr.size(); wb = sw_addr.size(); sb = start_cnt;
        rb = rs_addr.size(); db = done_cnt;
        cmd(2, 0);
        wait_start_complete(sb);
        collect(rb, db, 1, 1'b0);
        check("d_no_ctx", cw_addr.size() - cb, 0);
        check("d_state_writes", sw_addr.size() - wb, 1);
        check("d_row0_data", sw_data[wb], ROW0);

        // watchdog: complete never arrives
        sb = start_cnt; eb = err_cnt; db = done_cnt; srb = sr_addr.size(); rb = rs_addr.size();
        cmd(3, 2);
        feed(2, 1'b0);
        begin
            int g = 0;
            while (err_cnt == eb && g < TO + 100) begin tick(1); g++; end
        end
        tick(2);
        check("to_error", err_cnt - eb, 1);
        check("to_latency", err_cyc - start_cyc, TO + 2);
        check("to_no_done", done_cnt - db, 0);
        check("to_no_reads", sr_addr.size() - srb, 0);
        check("to_no_results", rs_addr.size() - rb, 0);
        check("to_idle", o_busy, 0);

        // reset in the middle of loading context
        cmd(3, 100);
        feed(20, 1'b0);
        check("pre_rst_busy", o_busy, 1);
        rst = 1'b1;
        #2;
        check("arst_ctrl", ctrl_vec(), 0);
        check("arst_ctx", {o_ctx_addr, o_ctx_data, o_qbit_num}, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        cb = cw_addr.size(); sb = start_cnt; rb = rs_addr.size(); db = done_cnt;
        cmd(3, 5);
        feed(5, 1'b0);
        tick(3);
        check_ctx(cb, 5, 1'b0);
        wait_start_complete(sb);
        collect(rb, db, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end
endmodule
